// File: rtl/ps2_scan_receiver_pkg.sv
// ps2_pkg: shared PS/2 receiver types and constants
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS = FRAME_BITS - 3;
endpackage

// File: rtl/ps2_scan_receiver_line_filter.sv
// ps2_line_filter: synchronises the PS/2 pads and debounces ps2_clk into a falling-edge pulse
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_data,
  output logic o_fall
);
  logic [1:0] r_clk_sync;
  logic [1:0] r_data_sync;
  logic [FILTER_LEN-1:0] r_shift;
  logic r_level;
  assign o_data = r_data_sync[1];
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_shift     <= '1;
      r_level     <= 1'b1;
      o_fall      <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
      r_shift     <= {r_shift[FILTER_LEN-2:0], r_clk_sync[1]};
      // level only moves on a unanimous window, so short glitches are held off
      r_level     <= (r_shift == '0) ? 1'b0 : (&r_shift) ? 1'b1 : r_level;
      o_fall      <= r_level && (r_shift == '0);
    end
  end
endmodule

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: PS/2 frame receiver delivering checked scan codes with the previous byte
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_scan_code,
  output logic [7:0] o_data_pre,
  output logic       o_ready,
  output logic       o_parity_err,
  output logic       o_frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic w_fall;
  logic w_data;
  state_t r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shreg;
  logic r_parity;
  logic [TW-1:0] r_timer;
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_ps2_clk  (i_ps2_clk),
    .i_ps2_data (i_ps2_data),
    .o_data     (w_data),
    .o_fall     (w_fall)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_shreg      <= '0;
      r_parity     <= 1'b0;
      r_timer      <= '0;
      o_scan_code  <= '0;
      o_data_pre   <= '0;
      o_ready      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_ready      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      if (w_fall) begin
        r_timer <= '0;
        case (r_state)
          IDLE: begin
            if (!w_data) begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
            end else o_frame_err <= 1'b1;
          end
          DATA: begin
            r_shreg   <= {w_data, r_shreg[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'(DATA_BITS - 1)) r_state <= PARITY;
          end
          PARITY: begin
            r_parity <= w_data;
            r_state  <= STOP;
          end
          default: begin
            r_state <= IDLE;
            if (!w_data) o_frame_err <= 1'b1;
            else if (^{r_shreg, r_parity}) begin
              o_data_pre  <= o_scan_code;
              o_scan_code <= r_shreg;
              o_ready     <= 1'b1;
            end else o_parity_err <= 1'b1;
          end
        endcase
      end else if (r_state == IDLE) r_timer <= '0;
      else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
        r_state     <= IDLE;
        r_timer     <= '0;
        o_frame_err <= 1'b1;
      end else r_timer <= r_timer + 1'b1;
    end
  end
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb_ps2_scan_receiver: table-driven frame vectors plus timeout, glitch and reset sequences
module tb_ps2_scan_receiver;
  import ps2_pkg::*;
  localparam int TMO = 400;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic [7:0] scan_code, data_pre;
  logic ready, parity_err, frame_err;
  int n_pass = 0, n_total = 0;
  int n_rdy = 0, n_perr = 0, n_ferr = 0, n_multi = 0;

  typedef struct {
    logic [7:0] data;
    logic bad_par;
    logic stop;
    int exp_rdy, exp_perr, exp_ferr;
    logic [7:0] exp_scan, exp_pre;
  } vec_t;
  vec_t vecs[6];

  ps2_scan_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_scan_code  (scan_code),
    .o_data_pre   (data_pre),
    .o_ready      (ready),
    .o_parity_err (parity_err),
    .o_frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n) begin
    n_rdy  += int'(ready);
    n_perr += int'(parity_err);
    n_ferr += int'(frame_err);
    if (int'(ready) + int'(parity_err) + int'(frame_err) > 1) n_multi++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_rdy = 0; n_perr = 0; n_ferr = 0;
  endtask

  // sends the first nbits of a frame, 40 clk per bit, data set while ps2_clk high
  task automatic send(input logic [7:0] d, input logic bad_par, input logic stop, input int nbits);
    logic [10:0] f;
    f = {stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_clk(10);
      ps2_clk = 1'b0;
      wait_clk(20);
      ps2_clk = 1'b1;
      wait_clk(10);
    end
    ps2_data = 1'b1;
  endtask

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C, 8'h00};
    vecs[1] = '{PS2_BREAK, 1'b0, 1'b1, 1, 0, 0, 8'hF0, 8'h1C};
    vecs[2] = '{8'h1C, 1'b0, 1'b1, 1, 0, 0, 8'h1C, 8'hF0};
    vecs[3] = '{8'h1D, 1'b1, 1'b1, 0, 1, 0, 8'h1C, 8'hF0};
    vecs[4] = '{8'h45, 1'b0, 1'b0, 0, 0, 1, 8'h1C, 8'hF0};
    vecs[5] = '{8'h23, 1'b0, 1'b1, 1, 0, 0, 8'h23, 8'h1C};

    wait_clk(3);
    chk("reset scan_code", int'(scan_code), 0);
    chk("reset data_pre", int'(data_pre), 0);
    chk("reset pulses", int'({ready, parity_err, frame_err}), 0);
    rst_n = 1'b1;
    wait_clk(20);

    foreach (vecs[k]) begin
      clear_counts();
      send(vecs[k].data, vecs[k].bad_par, vecs[k].stop, FRAME_BITS);
      wait_clk(30);
      chk($sformatf("v%0d ready", k), n_rdy, vecs[k].exp_rdy);
      chk($sformatf("v%0d parity_err", k), n_perr, vecs[k].exp_perr);
      chk($sformatf("v%0d frame_err", k), n_ferr, vecs[k].exp_ferr);
      chk($sformatf("v%0d scan_code", k), int'(scan_code), int'(vecs[k].exp_scan));
      chk($sformatf("v%0d data_pre", k), int'(data_pre), int'(vecs[k].exp_pre));
    end

    clear_counts();
    send(8'h55, 1'b0, 1'b1, 6);
    wait_clk(TMO + 100);
    chk("timeout frame_err", n_ferr, 1);
    chk("timeout no ready", n_rdy, 0);
    chk("timeout no parity_err", n_perr, 0);
    chk("timeout scan kept", int'(scan_code), 8'h23);

    clear_counts();
    send(8'h23, 1'b0, 1'b1, FRAME_BITS);
    wait_clk(30);
    chk("post-timeout ready", n_rdy, 1);
    chk("post-timeout frame_err", n_ferr, 0);
    chk("post-timeout scan_code", int'(scan_code), 8'h23);
    chk("post-timeout data_pre", int'(data_pre), 8'h23);

    clear_counts();
    ps2_clk = 1'b0;
    wait_clk(3);
    ps2_clk = 1'b1;
    wait_clk(40);
    chk("glitch pulses", n_rdy + n_perr + n_ferr, 0);

    clear_counts();
    send(8'h3A, 1'b0, 1'b1, 5);
    rst_n = 1'b0;
    #1;
    chk("midreset scan_code", int'(scan_code), 0);
    chk("midreset data_pre", int'(data_pre), 0);
    chk("midreset pulses", int'({ready, parity_err, frame_err}), 0);
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(20);
    chk("midreset no error", n_rdy + n_perr + n_ferr, 0);
    send(8'h16, 1'b0, 1'b1, FRAME_BITS);
    wait_clk(30);
    chk("after reset ready", n_rdy, 1);
    chk("after reset scan_code", int'(scan_code), 8'h16);
    chk("after reset data_pre", int'(data_pre), 8'h00);
    chk("one pulse at a time", n_multi, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
